// File: rtl/sobel_line_feeder.sv
// Three-line window feeder for a Sobel stage: two line buffers plus the live word form a (n-2, n-1, n) triple.
// Optional macro LINE_FEEDER_BORDER_EN also emits zero-padded triples during the first two rows.
module sobel_line_feeder #(
    parameter int unsigned LINE_WORDS  = 80,
    parameter int unsigned FRAME_LINES = 480,
    parameter int unsigned AW          = 7
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_data_valid,
    input  logic [63:0]   i_data,
    output logic          o_data_ack,
    output logic          o_line1_data_valid,
    output logic [63:0]   o_line1_data,
    input  logic          i_line1_data_ack,
    output logic          o_line2_data_valid,
    output logic [63:0]   o_line2_data,
    input  logic          i_line2_data_ack,
    output logic          o_line3_data_valid,
    output logic [63:0]   o_line3_data,
    input  logic          i_line3_data_ack,
    output logic          o_frame_done
);

    localparam int unsigned DW = 64;
    localparam int unsigned RW = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;
    localparam logic [AW-1:0] COL_LAST = AW'(LINE_WORDS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(FRAME_LINES - 1);

    typedef enum logic {S_FILL, S_STREAM} state_e;

    logic [DW-1:0] ram_a [LINE_WORDS];
    logic [DW-1:0] ram_b [LINE_WORDS];

    state_e        state_q, state_d;
    logic [AW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [2:0]    vld_q, vld_d;
    logic [DW-1:0] l1_q, l1_d, l2_q, l2_d, l3_q, l3_d;
    logic          frame_done_q, frame_done_d;

    logic [2:0]    lane_ack, lane_free;
    logic          accept, col_last, row_last, emit;
    logic [DW-1:0] rd_a, rd_b;

    assign lane_ack   = {i_line3_data_ack, i_line2_data_ack, i_line1_data_ack};
    assign lane_free  = ~vld_q | lane_ack;
    assign o_data_ack = ~i_rst & (&lane_free);
    assign accept     = i_data_valid & o_data_ack;
    assign col_last   = (col_q == COL_LAST);
    assign row_last   = (row_q == ROW_LAST);
    assign rd_a       = ram_a[col_q];
    assign rd_b       = ram_b[col_q];

    // Line buffers shift down one line per accepted word; contents are never reset.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            ram_a[col_q] <= rd_b;
            ram_b[col_q] <= i_data;
        end
    end

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        vld_d        = vld_q & ~lane_ack;
        l1_d         = l1_q;
        l2_d         = l2_q;
        l3_d         = l3_q;
        frame_done_d = 1'b0;
        emit         = 1'b0;

        if (accept) begin
            if (col_last) begin
                col_d = '0;
                if (row_last) begin
                    row_d        = '0;
                    frame_done_d = 1'b1;
                end else begin
                    row_d = row_q + RW'(1);
                end
            end else begin
                col_d = col_q + AW'(1);
            end
        end

        case (state_q)
            S_FILL:   if (accept && col_last && row_q == RW'(1)) state_d = S_STREAM;
            S_STREAM: if (accept && col_last && row_last)        state_d = S_FILL;
        endcase

`ifdef LINE_FEEDER_BORDER_EN
        emit = accept;
        if (emit) begin
            vld_d = 3'b111;
            l3_d  = i_data;
            if (state_q == S_FILL) begin
                l1_d = '0;
                l2_d = (row_q == '0) ? '0 : rd_b;
            end else begin
                l1_d = rd_a;
                l2_d = rd_b;
            end
        end
`else
        emit = accept && (state_q == S_STREAM);
        if (emit) begin
            vld_d = 3'b111;
            l1_d  = rd_a;
            l2_d  = rd_b;
            l3_d  = i_data;
        end
`endif
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= S_FILL;
            col_q        <= '0;
            row_q        <= '0;
            vld_q        <= '0;
            l1_q         <= '0;
            l2_q         <= '0;
            l3_q         <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            vld_q        <= vld_d;
            l1_q         <= l1_d;
            l2_q         <= l2_d;
            l3_q         <= l3_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign o_line1_data_valid = vld_q[0];
    assign o_line2_data_valid = vld_q[1];
    assign o_line3_data_valid = vld_q[2];
    assign o_line1_data       = l1_q;
    assign o_line2_data       = l2_q;
    assign o_line3_data       = l3_q;
    assign o_frame_done       = frame_done_q;

endmodule

// File: tb/tb_sobel_line_feeder.sv
// Directed bench for sobel_line_feeder with 4-word lines and 4-line frames; data word k = k.
module tb_sobel_line_feeder;

    logic        clk, rst;
    logic        in_valid;
    logic [63:0] in_data;
    logic        data_ack;
    logic        v1, v2, v3;
    logic [63:0] d1, d2, d3;
    logic        ack1, ack2, ack3;
    logic        frame_done;

    int checks = 0;
    int errors = 0;
    int fd_cnt = 0;
    logic [63:0] q1[$], q2[$], q3[$];

    sobel_line_feeder #(.LINE_WORDS(4), .FRAME_LINES(4), .AW(2)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_data_valid(in_valid), .i_data(in_data), .o_data_ack(data_ack),
        .o_line1_data_valid(v1), .o_line1_data(d1), .i_line1_data_ack(ack1),
        .o_line2_data_valid(v2), .o_line2_data(d2), .i_line2_data_ack(ack2),
        .o_line3_data_valid(v3), .o_line3_data(d3), .i_line3_data_ack(ack3),
        .o_frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every lane handshake and frame-done pulse.
    always @(posedge clk) begin
        if (v1 && ack1) q1.push_back(d1);
        if (v2 && ack2) q2.push_back(d2);
        if (v3 && ack3) q3.push_back(d3);
        if (frame_done) fd_cnt++;
    end

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; ack1 = 1'b1; ack2 = 1'b1; ack3 = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({v3, v2, v1, frame_done, data_ack} !== 5'b0) begin
            errors++; $display("FAIL reset_async got v=%b%b%b fd=%b ack=%b exp all 0", v3, v2, v1, frame_done, data_ack);
        end
        @(posedge clk); #1;
        checks++;
        if (d1 !== 64'd0 || d2 !== 64'd0 || d3 !== 64'd0 || data_ack !== 1'b0) begin
            errors++; $display("FAIL reset_hold got d=%0d/%0d/%0d ack=%b exp 0/0/0 0", d1, d2, d3, data_ack);
        end
        @(negedge clk); rst = 1'b0; #1;
        checks++;
        if (data_ack !== 1'b1) begin
            errors++; $display("FAIL reset_release got ack=%b exp 1", data_ack);
        end
    endtask

    task automatic test_basic();
        int fd_base;
        logic [2:0] exp_v;
        reset_dut();
        fd_base = fd_cnt;
        for (int kk = 0; kk < 16; kk++) begin
            @(negedge clk); in_valid = 1'b1; in_data = 64'(kk); #1;
            checks++;
            if (data_ack !== 1'b1) begin
                errors++; $display("FAIL basic_ack k=%0d got %b exp 1", kk, data_ack);
            end
            @(posedge clk); #1;
            exp_v = (kk >= 8) ? 3'b111 : 3'b000;
            checks++;
            if ({v3, v2, v1} !== exp_v) begin
                errors++; $display("FAIL basic_valid k=%0d got %b exp %b", kk, {v3, v2, v1}, exp_v);
            end
            if (kk >= 8) begin
                checks++;
                if (d1 !== 64'(kk - 8) || d2 !== 64'(kk - 4) || d3 !== 64'(kk)) begin
                    errors++; $display("FAIL basic_lanes k=%0d got %0d/%0d/%0d exp %0d/%0d/%0d", kk, d1, d2, d3, kk - 8, kk - 4, kk);
                end
            end
            checks++;
            if (frame_done !== (kk == 15)) begin
                errors++; $display("FAIL basic_frame_done k=%0d got %b exp %b", kk, frame_done, kk == 15);
            end
        end
        @(negedge clk); in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({v3, v2, v1, frame_done} !== 4'b0 || fd_cnt - fd_base != 1) begin
            errors++; $display("FAIL basic_drain got v=%b fd=%b pulses=%0d exp 000 0 1", {v3, v2, v1}, frame_done, fd_cnt - fd_base);
        end
    endtask

    task automatic test_backpressure();
        int b1, b2, b3;
        reset_dut();
        b1 = q1.size(); b2 = q2.size(); b3 = q3.size();
        for (int kk = 0; kk < 8; kk++) begin
            @(negedge clk); in_valid = 1'b1; in_data = 64'(kk);
        end
        @(negedge clk); in_data = 64'd8; ack2 = 1'b0;
        @(posedge clk);
        for (int c = 0; c < 3; c++) begin
            #1;
            in_data = 64'd9;
            checks++;
            if (data_ack !== 1'b0 || v2 !== 1'b1 || d2 !== 64'd4) begin
                errors++; $display("FAIL bp_hold c=%0d got ack=%b v2=%b d2=%0d exp 0 1 4", c, data_ack, v2, d2);
            end
            checks++;
            if ({v3, v1} !== ((c == 0) ? 2'b11 : 2'b00)) begin
                errors++; $display("FAIL bp_other c=%0d got v3v1=%b exp %b", c, {v3, v1}, (c == 0) ? 2'b11 : 2'b00);
            end
            if (c < 2) @(posedge clk);
        end
        @(negedge clk); ack2 = 1'b1; #1;
        checks++;
        if (data_ack !== 1'b1) begin
            errors++; $display("FAIL bp_release got ack=%b exp 1", data_ack);
        end
        @(posedge clk); #1;
        checks++;
        if ({v3, v2, v1} !== 3'b111 || d1 !== 64'd1 || d2 !== 64'd5 || d3 !== 64'd9) begin
            errors++; $display("FAIL bp_resume got v=%b %0d/%0d/%0d exp 111 1/5/9", {v3, v2, v1}, d1, d2, d3);
        end
        for (int kk = 10; kk < 16; kk++) begin
            @(negedge clk); in_data = 64'(kk);
        end
        @(negedge clk); in_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (q1.size() - b1 != 8 || q2.size() - b2 != 8 || q3.size() - b3 != 8) begin
            errors++; $display("FAIL bp_count got %0d/%0d/%0d exp 8/8/8", q1.size() - b1, q2.size() - b2, q3.size() - b3);
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (q1[b1 + i] !== 64'(i) || q2[b2 + i] !== 64'(i + 4) || q3[b3 + i] !== 64'(i + 8)) begin
                    errors++; $display("FAIL bp_order i=%0d got %0d/%0d/%0d exp %0d/%0d/%0d", i, q1[b1 + i], q2[b2 + i], q3[b3 + i], i, i + 4, i + 8);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int b1, b2, b3, fd_base, kk;
        reset_dut();
        b1 = q1.size(); b2 = q2.size(); b3 = q3.size(); fd_base = fd_cnt;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk); in_valid = 1'b1; in_data = 64'(k); #1;
            checks++;
            if (data_ack !== 1'b1) begin
                errors++; $display("FAIL b2b_ack k=%0d got %b exp 1", k, data_ack);
            end
        end
        @(negedge clk); in_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (fd_cnt - fd_base != 2) begin
            errors++; $display("FAIL b2b_frame_done got %0d pulses exp 2", fd_cnt - fd_base);
        end
        checks++;
        if (q1.size() - b1 != 16 || q2.size() - b2 != 16 || q3.size() - b3 != 16) begin
            errors++; $display("FAIL b2b_count got %0d/%0d/%0d exp 16/16/16", q1.size() - b1, q2.size() - b2, q3.size() - b3);
        end else begin
            for (int i = 0; i < 16; i++) begin
                kk = (i < 8) ? 8 + i : 24 + (i - 8);
                checks++;
                if (q1[b1 + i] !== 64'(kk - 8) || q2[b2 + i] !== 64'(kk - 4) || q3[b3 + i] !== 64'(kk)) begin
                    errors++; $display("FAIL b2b_order k=%0d got %0d/%0d/%0d exp %0d/%0d/%0d", kk, q1[b1 + i], q2[b2 + i], q3[b3 + i], kk - 8, kk - 4, kk);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int fd_base;
        reset_dut();
        ack1 = 1'b0; ack2 = 1'b0; ack3 = 1'b0;
        for (int kk = 0; kk < 9; kk++) begin
            @(negedge clk); in_valid = 1'b1; in_data = 64'(kk);
        end
        @(negedge clk); in_valid = 1'b0; #1;
        checks++;
        if ({v3, v2, v1} !== 3'b111 || data_ack !== 1'b0) begin
            errors++; $display("FAIL mid_pending got v=%b ack=%b exp 111 0", {v3, v2, v1}, data_ack);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({v3, v2, v1, data_ack, frame_done} !== 5'b0 || d1 !== 64'd0 || d2 !== 64'd0 || d3 !== 64'd0) begin
            errors++; $display("FAIL mid_reset got v=%b ack=%b d=%0d/%0d/%0d exp all 0", {v3, v2, v1}, data_ack, d1, d2, d3);
        end
        @(negedge clk); rst = 1'b0; ack1 = 1'b1; ack2 = 1'b1; ack3 = 1'b1;
        fd_base = fd_cnt;
        for (int kk = 0; kk < 16; kk++) begin
            in_valid = 1'b1; in_data = 64'(kk);
            @(posedge clk); #1;
            checks++;
            if (kk < 8 && {v3, v2, v1} !== 3'b000) begin
                errors++; $display("FAIL mid_fill k=%0d got v=%b exp 000", kk, {v3, v2, v1});
            end else if (kk >= 8 && ({v3, v2, v1} !== 3'b111 || d1 !== 64'(kk - 8) || d2 !== 64'(kk - 4) || d3 !== 64'(kk))) begin
                errors++; $display("FAIL mid_stream k=%0d got v=%b %0d/%0d/%0d exp 111 %0d/%0d/%0d", kk, {v3, v2, v1}, d1, d2, d3, kk - 8, kk - 4, kk);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (fd_cnt - fd_base != 1) begin
            errors++; $display("FAIL mid_frame_done got %0d pulses exp 1", fd_cnt - fd_base);
        end
    endtask

    task automatic test_random();
        int b1, b2, b3, fd_base, k, cyc, kk;
        reset_dut();
        b1 = q1.size(); b2 = q2.size(); b3 = q3.size(); fd_base = fd_cnt;
        k = 0; cyc = 0;
        while (k < 64 && cyc < 3000) begin
            @(negedge clk);
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 64'(k);
            ack1 = ($urandom_range(0, 3) != 0);
            ack2 = ($urandom_range(0, 3) != 0);
            ack3 = ($urandom_range(0, 3) != 0);
            #1;
            if (in_valid && data_ack) k++;
            cyc++;
        end
        @(negedge clk); in_valid = 1'b0; ack1 = 1'b1; ack2 = 1'b1; ack3 = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (k != 64) begin
            errors++; $display("FAIL rand_timeout accepted %0d words exp 64", k);
        end
        checks++;
        if (fd_cnt - fd_base != 4) begin
            errors++; $display("FAIL rand_frame_done got %0d pulses exp 4", fd_cnt - fd_base);
        end
        checks++;
        if (q1.size() - b1 != 32 || q2.size() - b2 != 32 || q3.size() - b3 != 32) begin
            errors++; $display("FAIL rand_count got %0d/%0d/%0d exp 32/32/32", q1.size() - b1, q2.size() - b2, q3.size() - b3);
        end else begin
            for (int i = 0; i < 32; i++) begin
                kk = 16 * (i / 8) + 8 + (i % 8);
                checks++;
                if (q1[b1 + i] !== 64'(kk - 8) || q2[b2 + i] !== 64'(kk - 4) || q3[b3 + i] !== 64'(kk)) begin
                    errors++; $display("FAIL rand_order k=%0d got %0d/%0d/%0d exp %0d/%0d/%0d", kk, q1[b1 + i], q2[b2 + i], q3[b3 + i], kk - 8, kk - 4, kk);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_data = 64'd0;
        ack1 = 1'b1; ack2 = 1'b1; ack3 = 1'b1;
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
